// File: rtl/instr_pkg.sv
// Shared instruction constants for the encoder, the CPU decoder and ALU control.
// Also holds the loader state encoding and small word-packing helpers.
package instr_pkg;

   localparam logic [3:0] KIND_ADD  = 4'd0;
   localparam logic [3:0] KIND_SUB  = 4'd1;
   localparam logic [3:0] KIND_AND  = 4'd2;
   localparam logic [3:0] KIND_OR   = 4'd3;
   localparam logic [3:0] KIND_SLT  = 4'd4;
   localparam logic [3:0] KIND_ADDI = 4'd5;
   localparam logic [3:0] KIND_SLTI = 4'd6;
   localparam logic [3:0] KIND_BEQ  = 4'd7;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_SLTI  = 6'd10;
   localparam logic [5:0] OP_BEQ   = 6'd4;

   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_FULL = 2'd1,
      ST_DONE = 2'd2
   } enc_state_t;

   function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
      return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
   endfunction

   function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write channels of the encoder.
// Both channels transfer on a rising edge where valid and ready are both 1; valid never waits on ready.
interface instr_encoder_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid_i;
   logic              req_ready_o;
   logic [3:0]        kind_i;
   logic [4:0]        rs_i;
   logic [4:0]        rt_i;
   logic [4:0]        rd_i;
   logic [15:0]       imm_i;
   logic              im_valid_o;
   logic              im_ready_i;
   logic [ADDR_W-1:0] im_addr_o;
   logic [31:0]       im_data_o;

   modport master (
      output req_valid_i, kind_i, rs_i, rt_i, rd_i, imm_i, im_ready_i,
      input  req_ready_o, im_valid_o, im_addr_o, im_data_o
   );

   modport slave (
      input  req_valid_i, kind_i, rs_i, rt_i, rd_i, imm_i, im_ready_i,
      output req_ready_o, im_valid_o, im_addr_o, im_data_o
   );
endinterface

// File: rtl/instr_field_pack.sv
// Combinational packer: symbolic instruction kind plus fields to a 32-bit MIPS word.
// Kinds 8-15 give legal=0 and a zero word.
module instr_field_pack
   import instr_pkg::*;
(
   input  logic [3:0]  kind,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imm,
   output logic [31:0] word,
   output logic        legal
);

   always_comb begin
      word  = 32'd0;
      legal = 1'b1;
      case (kind)
         KIND_ADD:  word = pack_r(rs, rt, rd, FUNCT_ADD);
         KIND_SUB:  word = pack_r(rs, rt, rd, FUNCT_SUB);
         KIND_AND:  word = pack_r(rs, rt, rd, FUNCT_AND);
         KIND_OR:   word = pack_r(rs, rt, rd, FUNCT_OR);
         KIND_SLT:  word = pack_r(rs, rt, rd, FUNCT_SLT);
         KIND_ADDI: word = pack_i(OP_ADDI, rs, rt, imm);
         KIND_SLTI: word = pack_i(OP_SLTI, rs, rt, imm);
         KIND_BEQ:  word = pack_i(OP_BEQ, rs, rt, imm);
         default:   legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes requests and writes them to sequential instruction-memory
// addresses through a one-entry output register; stops after DEPTH_WORDS words.
module instr_encoder
   import instr_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int BASE_ADDR   = 0,
   parameter int DEPTH_WORDS = 32,
   localparam int CNT_W      = $clog2(DEPTH_WORDS + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   instr_encoder_if.slave    bus,
   input  logic              clear_i,
   output logic [CNT_W-1:0]  count_o,
   output logic              full_o,
   output logic              done_o,
   output logic              err_o,
   output enc_state_t        state_o
);

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BASE_ADDR + 4 * (DEPTH_WORDS - 1));

   enc_state_t        state, state_nx;
   logic              im_valid;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_data;
   logic [ADDR_W-1:0] issue_ptr;
   logic [CNT_W-1:0]  count;
   logic              err;
   logic              req_ready;
   logic [31:0]       word;
   logic              legal;
   logic              accept, legal_accept, drain, last_slot;

   instr_field_pack u_pack (
      .kind  (bus.kind_i),
      .rs    (bus.rs_i),
      .rt    (bus.rt_i),
      .rd    (bus.rd_i),
      .imm   (bus.imm_i),
      .word  (word),
      .legal (legal)
   );

   assign accept       = bus.req_valid_i & req_ready;
   assign legal_accept = accept & legal;
   assign drain        = im_valid & bus.im_ready_i;
   assign last_slot    = (issue_ptr == LAST);

   always_ff @(posedge clk_i) begin
      if (!rst_i) state <= ST_LOAD;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (clear_i) begin
         state_nx = ST_LOAD;
      end else begin
         case (state)
            ST_LOAD: if (legal_accept && last_slot) state_nx = ST_FULL;
            ST_FULL: if (!im_valid || bus.im_ready_i) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_DONE;
            default: state_nx = ST_LOAD;
         endcase
      end
   end

   always_comb begin
      req_ready = (state == ST_LOAD) && (!im_valid || bus.im_ready_i) && !clear_i;
      full_o    = (state != ST_LOAD);
      done_o    = (state == ST_DONE);
   end

   // Clear drops the pending word but leaves the last address/data visible.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         im_valid  <= 1'b0;
         im_addr   <= BASE;
         im_data   <= 32'd0;
         issue_ptr <= BASE;
         count     <= '0;
         err       <= 1'b0;
      end else if (clear_i) begin
         im_valid  <= 1'b0;
         issue_ptr <= BASE;
         count     <= '0;
         err       <= 1'b0;
      end else begin
         if (legal_accept) begin
            im_valid <= 1'b1;
            im_addr  <= issue_ptr;
            im_data  <= word;
            if (!last_slot) issue_ptr <= issue_ptr + ADDR_W'(4);
         end else if (drain) begin
            im_valid <= 1'b0;
         end
         if (drain) count <= count + CNT_W'(1);
         if (accept && !legal) err <= 1'b1;
      end
   end

   assign bus.req_ready_o = req_ready;
   assign bus.im_valid_o  = im_valid;
   assign bus.im_addr_o   = im_addr;
   assign bus.im_data_o   = im_data;
   assign count_o         = count;
   assign err_o           = err;
   assign state_o         = state;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Instruction encoder and program loader, the write-side counterpart of the control decoder. It takes symbolic instruction requests (kind plus register and immediate fields) over a valid/ready handshake and packs each into a 32-bit MIPS word. It writes the words to sequential instruction-memory addresses through a one-entry output register with valid/ready backpressure. It is used by the test harness and boot path to fill instruction memory before the single-cycle CPU runs.

Parameters:
ADDR_W, 32, width of instruction-memory byte address
BASE_ADDR, 0, byte address of first written word (multiple of 4)
DEPTH_WORDS, 32, number of word slots available; loader stops after this many

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
kind_i  in  4  0 ADD,1 SUB,2 AND,3 OR,4 SLT,5 ADDI,6 SLTI,7 BEQ,8-15 illegal
rs_i  in  5  source register
rt_i  in  5  second source / I-type destination
rd_i  in  5  R-type destination
imm_i  in  16  immediate / branch word offset
clear_i  in  1  restart load at BASE_ADDR, drop pending word
im_valid_o  out  1  write word pending
im_ready_i  in  1  memory accepts write
im_addr_o  out  ADDR_W  byte address of pending word
im_data_o  out  32  encoded word
count_o  out  $clog2(DEPTH_WORDS+1)  words written (downstream handshakes)
full_o  out  1  DEPTH_WORDS requests issued; no more accepted
done_o  out  1  full_o and output register empty
err_o  out  1  sticky: illegal kind seen

Behaviour:
- Reset (rst_i=0 at posedge): im_valid_o=0, im_addr_o=BASE_ADDR, im_data_o=0, count_o=0, full_o=0, done_o=0, err_o=0, issue pointer=BASE_ADDR, state=LOAD.
- Encoding: R-type {6'd0,rs,rt,rd,5'd0,funct}, with funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A. I-type {op,rs,rt,imm}, with op ADDI 6'd8, SLTI 6'd10, BEQ 6'd4. rd_i is ignored for I-type. imm_i is passed unmodified.
- req_ready_o = (state==LOAD) & (!im_valid_o | im_ready_i) & clear_i==0. Combinational; gives full throughput, one word per cycle.
- Legal request accepted at edge N: im_valid_o=1, im_data_o=encoded word, im_addr_o=issue pointer from edge N; issue pointer += 4. Latency is one cycle.
- Illegal request: it is accepted (handshake completes) but no word is emitted. err_o is set and sticky until reset or clear_i. The issue pointer is unchanged. A pending word drains normally.
- Downstream: im_valid_o & im_ready_i at an edge completes the write and increments count_o. im_valid_o stays 1 if a new request is accepted in the same cycle, otherwise it drops to 0. While im_valid_o=1 and !im_ready_i, im_addr_o and im_data_o hold stable.
- State machine:
  - LOAD → FULL on the edge where the legal request issuing slot DEPTH_WORDS-1 is accepted. full_o=1 from that edge.
  - FULL → DONE when the output register empties. done_o=1.
  - DONE holds until clear_i or reset.
- Wrap-around: the issue pointer never exceeds BASE_ADDR+4*(DEPTH_WORDS-1). No wrap occurs; FULL blocks further requests.
- clear_i=1 at an edge, from any state:
  - im_valid_o=0, and the pending word is discarded (not counted).
  - issue pointer=BASE_ADDR, count_o=0, full_o=0, done_o=0, err_o=0, state=LOAD.
  - clear_i has priority over a simultaneous request (not accepted) and a simultaneous downstream handshake (not counted).
- Reset mid-operation behaves identically to clear plus the full reset values. A pending word is lost.

Decomposition:
- Shared package instr_pkg: kind codes (KIND_ADD..KIND_BEQ), opcode constants (OP_RTYPE=0, OP_ADDI=8, OP_SLTI=10, OP_BEQ=4), funct constants. The CPU decoder and ALU control share the same constants.
- Sub-module instr_field_pack: purely combinational. Maps kind and fields to {word, legal}. The top holds the handshake, pointer, counter and FSM.

Test Plan:
- Reset, then ADDI rs=0 rt=1 imm=5 with im_ready_i=1 → next cycle im_valid_o=1, im_addr_o=0x0, im_data_o=0x20010005; count_o=1 after the write.
- Back-to-back ADD rs=1 rt=2 rd=3, BEQ rs=1 rt=2 imm=0xFFFF, SLTI rs=1 rt=4 imm=10 → words 0x00221820, 0x1022FFFF, 0x2824000A at 0x0, 0x4, 0x8 on consecutive cycles.
- Stall: hold im_ready_i=0 for 3 cycles with req_valid_i=1 → req_ready_o=0 and address/data stable; release → drain, then the next word the cycle after.
- Illegal kind=9 between two ADDs → err_o=1, only 2 writes, at addresses 0x0 and 0x4.
- Issue 32 legal requests → full_o=1 after the 32nd accept, req_ready_o=0, done_o=1 after the last write, count_o=32; the 33rd request is never accepted.
- clear_i asserted with a word pending and im_ready_i=1 → no write counted, count_o=0, next accepted word goes to BASE_ADDR, err_o cleared.
